// File: rtl/sha2_wt_sched.sv
// sha2_wt_sched: SHA-2 message schedule generator.
// Takes one 1024-bit message block per slave beat and streams W_0..W_63 (SHA-224/256)
// or W_0..W_79 (SHA-384/512) on the master stream. It uses a 16-entry circular buffer.
module sha2_wt_sched #(
    parameter int P_S_AXIS_DATA_WIDTH  = 1024,
    parameter int P_M_AXIS_DATA_WIDTH  = 64,
    parameter int P_M_AXIS_TUSER_WIDTH = 7
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic [1:0]                      sha_type,
    input  logic                            en,
    input  logic [P_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [P_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [P_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser
);

    localparam int TW = P_M_AXIS_TUSER_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [63:0]     buffer    [16];
    logic [63:0]     load_word [16];
    logic [63:0]     out_data;
    logic [63:0]     sched_word;
    logic            out_valid;
    logic            wide;
    logic            is_last;
    logic [TW-1:0]   t;
    logic [TW-1:0]   t_next;
    logic [3:0]      slot;
    logic            final_round;
    logic            accept;
    logic            out_hs;
    logic            advance;
    logic            unused_sha_variant;

    // SHA-224 and SHA-256 share one schedule, and SHA-384 and SHA-512 share another.
    // Only the width bit of sha_type matters here.
    assign unused_sha_variant = sha_type[0];

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    assign final_round   = (state == RUN) && (wide ? (t == TW'(79)) : (t == TW'(63)));
    assign s_axis_tready = en && !axis_reset &&
                           ((state == IDLE) || ((state == RUN) && final_round && m_axis_tready));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_hs        = out_valid && m_axis_tready;
    assign advance       = (state == RUN) && out_hs && !final_round;
    assign t_next        = t + TW'(1);
    assign slot          = t_next[3:0];

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = final_round && is_last;
    assign m_axis_tuser  = t;

    // Split the incoming block into the 16 initial words, depending on the requested width.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            load_word[i] = '0;
            if (sha_type[1])
                load_word[i] = s_axis_tdata[P_S_AXIS_DATA_WIDTH-1-64*i -: 64];
            else
                load_word[i] = {32'b0, s_axis_tdata[511-32*i -: 32]};
        end
    end

    // Expand the next schedule word. The slot being overwritten holds W[n-16].
    always_comb begin
        sched_word = '0;
        if (wide)
            sched_word = sig1_64(buffer[slot - 4'd2]) + buffer[slot - 4'd7]
                       + sig0_64(buffer[slot - 4'd15]) + buffer[slot];
        else
            sched_word = {32'b0, sig1_32(buffer[slot - 4'd2][31:0]) + buffer[slot - 4'd7][31:0]
                               + sig0_32(buffer[slot - 4'd15][31:0]) + buffer[slot][31:0]};
    end

    // FSM next state: leave IDLE on accept; return to IDLE after the last round unless a new block is chained.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (out_hs && final_round && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) state <= IDLE;
        else            state <= state_next;
    end

    // Datapath: load a block on accept, step the round on each output handshake, and drop valid after the last round.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            t         <= '0;
            wide      <= 1'b0;
            is_last   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 16; i++) buffer[i] <= '0;
        end else if (accept) begin
            wide      <= sha_type[1];
            is_last   <= s_axis_tlast;
            t         <= '0;
            out_data  <= load_word[0];
            out_valid <= 1'b1;
            for (int i = 0; i < 16; i++) buffer[i] <= load_word[i];
        end else if (advance) begin
            t <= t_next;
            if (t_next < TW'(16)) begin
                out_data <= buffer[slot];
            end else begin
                buffer[slot] <= sched_word;
                out_data     <= sched_word;
            end
        end else if ((state == RUN) && out_hs && final_round) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha2_wt_sched.sv
// tb_sha2_wt_sched: randomized and directed checks of sha2_wt_sched against a reference schedule model.
module tb_sha2_wt_sched;

    logic          clk = 1'b0;
    logic          axis_reset;
    logic [1:0]    sha_type;
    logic          en;
    logic [1023:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [63:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [6:0]    m_axis_tuser;

    typedef struct {
        logic [63:0] data;
        logic [6:0]  user;
        logic        last;
        logic        fin;
    } beat_t;

    beat_t       exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          bp_mode  = 0;
    logic [63:0] cap [80];
    int          beats    = 0;
    int          run_len  = 0;
    int          max_run  = 0;
    logic        held_pending = 1'b0;
    beat_t       held;
    beat_t       e;
    logic        exp_tready;

    sha2_wt_sched dut (
        .axis_aclk     (clk),
        .axis_reset    (axis_reset),
        .sha_type      (sha_type),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference model: compute the whole schedule with the textbook recurrence and queue the expected beats.
    task automatic pushBlock(input logic [1023:0] blk, input logic wide, input logic last);
        logic [63:0] w [80];
        logic [31:0] a, b;
        int rounds;
        beat_t bt;
        rounds = wide ? 80 : 64;
        for (int i = 0; i < 16; i++)
            w[i] = wide ? blk[1023-64*i -: 64] : {32'b0, blk[511-32*i -: 32]};
        for (int i = 16; i < rounds; i++) begin
            if (wide) begin
                w[i] = (rotr64(w[i-2], 19) ^ rotr64(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
                     + (rotr64(w[i-15], 1) ^ rotr64(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
            end else begin
                a = w[i-2][31:0];
                b = w[i-15][31:0];
                w[i] = {32'b0, (rotr32(a, 17) ^ rotr32(a, 19) ^ (a >> 10)) + w[i-7][31:0]
                             + (rotr32(b, 7) ^ rotr32(b, 18) ^ (b >> 3)) + w[i-16][31:0]};
            end
        end
        for (int i = 0; i < rounds; i++) begin
            bt.data = w[i];
            bt.user = 7'(i);
            bt.fin  = (i == rounds - 1);
            bt.last = last && (i == rounds - 1);
            exp_q.push_back(bt);
        end
    endtask

    // Offer one block and wait for its accept. After accept, the expectations are queued and tvalid is dropped.
    task automatic applyStimulus(input logic [1023:0] blk, input logic [1:0] typ, input logic last);
        bit done = 0;
        s_axis_tdata  = blk;
        sha_type      = typ;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                pushBlock(blk, typ[1], last);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_axis_tvalid) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] randBlock();
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [1023:0] abcBlock(input logic wide);
        logic [1023:0] b;
        b = randBlock();
        if (wide) b = {64'h6162638000000000, 896'b0, 64'h18};
        else      b[511:0] = {32'h61626380, 448'b0, 32'h18};
        return b;
    endfunction

    task automatic clearCapture();
        for (int i = 0; i < 80; i++) cap[i] = '0;
        beats   = 0;
        max_run = 0;
    endtask

    // Downstream ready generator: always ready, random, or scripted stalls at rounds 5, 20 and the final round.
    initial begin : ready_gen
        int   stall_cnt = 0;
        logic [6:0] stalled_user = 7'h7f;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                m_axis_tready = 1'b1;
            end else if (bp_mode == 1) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
            end else if (stall_cnt > 0) begin
                m_axis_tready = 1'b0;
                stall_cnt--;
            end else if (m_axis_tvalid && m_axis_tuser != stalled_user &&
                         (m_axis_tuser == 7'd5 || m_axis_tuser == 7'd20 || m_axis_tuser == 7'd63)) begin
                m_axis_tready = 1'b0;
                stall_cnt     = 2;
                stalled_user  = m_axis_tuser;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard every output handshake, check hold stability and the accept-ready rule.
    always @(negedge clk) begin
        exp_tready = en && !axis_reset &&
                     (!m_axis_tvalid || (m_axis_tready && exp_q.size() > 0 && exp_q[0].fin));
        checkOutput("s_tready", 64'(s_axis_tready), 64'(exp_tready));
        if (axis_reset) begin
            held_pending = 1'b0;
            run_len      = 0;
        end else begin
            if (held_pending) begin
                checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
                checkOutput("hold_data", m_axis_tdata, held.data);
                checkOutput("hold_user", 64'(m_axis_tuser), 64'(held.user));
                checkOutput("hold_last", 64'(m_axis_tlast), 64'(held.last));
                held_pending = 1'b0;
            end
            if (m_axis_tvalid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("tdata", m_axis_tdata, e.data);
                        checkOutput("tuser", 64'(m_axis_tuser), 64'(e.user));
                        checkOutput("tlast", 64'(m_axis_tlast), 64'(e.last));
                    end
                    if (m_axis_tuser < 7'd80) cap[m_axis_tuser] = m_axis_tdata;
                    beats++;
                end else begin
                    held_pending = 1'b1;
                    held.data    = m_axis_tdata;
                    held.user    = m_axis_tuser;
                    held.last    = m_axis_tlast;
                end
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin : main
        bit done;
        axis_reset    = 1'b1;
        en            = 1'b1;
        sha_type      = 2'b00;
        s_axis_tdata  = randBlock();
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_last", 64'(m_axis_tlast), 64'd0);
        checkOutput("rst_user", 64'(m_axis_tuser), 64'd0);
        checkOutput("rst_data", m_axis_tdata, 64'd0);
        @(posedge clk);
        #1;
        axis_reset    = 1'b0;
        s_axis_tvalid = 1'b0;

        $display("[TB] SHA-256 abc block");
        clearCapture();
        applyStimulus(abcBlock(1'b0), 2'b00, 1'b1);
        waitDrain();
        checkOutput("abc256_W0", cap[0], 64'h61626380);
        checkOutput("abc256_W15", cap[15], 64'h18);
        checkOutput("abc256_W16", cap[16], 64'h61626380);
        checkOutput("abc256_W17", cap[17], 64'h000F0000);
        checkOutput("abc256_W18", cap[18], 64'h7DA86405);
        checkOutput("abc256_W19", cap[19], 64'h600003C6);
        checkOutput("abc256_beats", 64'(beats), 64'd64);

        $display("[TB] SHA-512 abc block");
        clearCapture();
        applyStimulus(abcBlock(1'b1), 2'b10, 1'b1);
        waitDrain();
        checkOutput("abc512_W16", cap[16], 64'h6162638000000000);
        checkOutput("abc512_W17", cap[17], 64'h00030000000000C0);
        checkOutput("abc512_beats", 64'(beats), 64'd80);

        $display("[TB] back-to-back SHA-256 blocks");
        clearCapture();
        applyStimulus(randBlock(), 2'b00, 1'b0);
        applyStimulus(randBlock(), 2'b01, 1'b1);
        waitDrain();
        checkOutput("b2b_beats", 64'(beats), 64'd128);
        checkOutput("b2b_contiguous", 64'(max_run), 64'd128);

        $display("[TB] scripted backpressure");
        bp_mode = 2;
        clearCapture();
        applyStimulus(abcBlock(1'b0), 2'b00, 1'b1);
        waitDrain();
        checkOutput("bp_W18", cap[18], 64'h7DA86405);
        checkOutput("bp_beats", 64'(beats), 64'd64);
        bp_mode = 0;

        $display("[TB] en low in IDLE");
        en            = 1'b0;
        s_axis_tdata  = randBlock();
        s_axis_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("en0_tready", 64'(s_axis_tready), 64'd0);
            checkOutput("en0_valid", 64'(m_axis_tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        en            = 1'b1;

        $display("[TB] en dropped and sha_type toggled mid-block");
        applyStimulus(randBlock(), 2'b10, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        en            = 1'b0;
        sha_type      = 2'b00;
        s_axis_tdata  = randBlock();
        s_axis_tvalid = 1'b1;
        waitDrain();
        repeat (10) begin
            @(negedge clk);
            checkOutput("en_drop_idle", 64'(m_axis_tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        en            = 1'b1;

        $display("[TB] randomized blocks with random backpressure");
        bp_mode = 1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(randBlock(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            sha_type = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) waitDrain();
        end
        waitDrain();
        bp_mode = 0;

        $display("[TB] reset mid SHA-512 block");
        applyStimulus(randBlock(), 2'b11, 1'b1);
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tuser == 7'd29) done = 1;
        end
        if (!done) checkOutput("reach_t29_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        axis_reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        axis_reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("midrst_user", 64'(m_axis_tuser), 64'd0);
        @(posedge clk);
        #1;
        clearCapture();
        applyStimulus(abcBlock(1'b0), 2'b00, 1'b1);
        waitDrain();
        checkOutput("post_rst_W0", cap[0], 64'h61626380);
        checkOutput("post_rst_W17", cap[17], 64'h000F0000);
        checkOutput("post_rst_W19", cap[19], 64'h600003C6);
        checkOutput("post_rst_beats", 64'(beats), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
